// File: rtl/ram_seq_pkg.sv
// Shared defaults and state encoding for the RAM sequencing controller.
package ram_seq_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 16;
  localparam int SCAN_DIV_DEF = 250;
  localparam logic [ADDR_W_DEF-1:0] MAX_ADDR = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/scan_timer.sv
// Counts tick pulses while enabled and not frozen; o_adv flags the tick that
// completes a SCAN_DIV period (same cycle, combinational).
module scan_timer #(
  parameter int SCAN_DIV = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_auto_en,
  input  logic i_freeze,
  output logic o_adv
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_count;

  assign w_count = i_auto_en && i_tick && !i_freeze;
  assign o_adv   = w_count && (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_auto_en) begin
      r_cnt <= '0;
    end else if (w_count) begin
      r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ram_seq_ctrl.sv
// Arbitrates manual write, manual step, auto-scan and full clear onto one RAM port.
// Define RAM_SEQ_WR_AUTOINC_EN to advance the address after every manual write.
module ram_seq_ctrl
  import ram_seq_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              wr_req,
  input  logic              step_req,
  input  logic              clr_req,
  input  logic              auto_en,
  input  logic [DATA_W-1:0] din,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output state_t            o_dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
`ifdef RAM_SEQ_WR_AUTOINC_EN
  localparam logic [ADDR_W-1:0] WR_INC = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] WR_INC = '0;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_we;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] w_din_nxt;
  logic [ADDR_W-1:0] r_saved_addr;
  logic [ADDR_W-1:0] w_saved_nxt;
  logic              r_step_pend;
  logic              w_pend_nxt;
  logic              w_adv;
  logic              w_freeze;

  assign w_freeze = (r_state != ST_IDLE);

  scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .clk       (clk),
    .rst_n     (reset),
    .i_tick    (tick),
    .i_auto_en (auto_en),
    .i_freeze  (w_freeze),
    .o_adv     (w_adv)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
        end else if (wr_req) begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: w_state_nxt = ST_IDLE;
      ST_CLEAR: begin
        if (r_addr == LAST_ADDR) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered port values for the next cycle; the auto advance is silently
  // lost whenever any manual request wins the IDLE arbitration.
  always_comb begin
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_din_nxt   = r_din;
    w_saved_nxt = r_saved_addr;
    w_pend_nxt  = r_step_pend;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_saved_nxt = r_addr;
          w_addr_nxt  = '0;
          w_din_nxt   = '0;
          w_we_nxt    = 1'b1;
        end else if (wr_req) begin
          w_din_nxt  = din;
          w_we_nxt   = 1'b1;
          w_pend_nxt = step_req;
        end else if (step_req || w_adv) begin
          w_addr_nxt = r_addr + 1'b1;
        end
      end
      ST_WRITE: begin
        w_addr_nxt = r_addr + ADDR_W'(r_step_pend | step_req) + WR_INC;
        w_pend_nxt = 1'b0;
      end
      ST_CLEAR: begin
        if (r_addr == LAST_ADDR) begin
          w_addr_nxt = r_saved_addr;
        end else begin
          w_addr_nxt = r_addr + 1'b1;
          w_we_nxt   = 1'b1;
        end
      end
      default: w_we_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_din        <= '0;
      r_saved_addr <= '0;
      r_step_pend  <= 1'b0;
    end else begin
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_din        <= w_din_nxt;
      r_saved_addr <= w_saved_nxt;
      r_step_pend  <= w_pend_nxt;
    end
  end

  assign ram_we      = r_we;
  assign ram_addr    = r_addr;
  assign ram_din     = r_din;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule
